// File: rtl/conv_job_sched.sv
// Job queue and sequencer in front of ren_conv: buffers layer descriptors, programs cfg,
// pulses start, waits for done with a watchdog, and emits one completion record per job.
module conv_job_sched #(
   parameter  int DEPTH   = 4,
   parameter  int TAG_W   = 4,
   parameter  int TIMEOUT = 4096,
   localparam int CFG_W   = 35,
   localparam int DESC_W  = CFG_W + TAG_W,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [DESC_W-1:0] desc_data,
   input  logic              abort,
   output logic [CFG_W-1:0]  cfg,
   output logic              conv_start,
   output logic              conv_soft_reset,
   input  logic              conv_done,
   input  logic              conv_ovf,
   output logic              cmp_valid,
   input  logic              cmp_ready,
   output logic [TAG_W-1:0]  cmp_tag,
   output logic [1:0]        cmp_status,
   output logic [CNT_W-1:0]  q_count,
   output logic              busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, ARM, RUN, KILL, CMP} state_t;

   logic [DESC_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr;
   logic [AW:0]       r_rd;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [DESC_W-1:0] w_head;

   state_t            r_state;
   logic [CFG_W-1:0]  r_cfg;
   logic [TAG_W-1:0]  r_tag;
   logic [1:0]        r_status;
   logic              r_start;
   logic              r_soft_reset;
   logic              r_cmp_valid;
   logic [WD_W-1:0]   r_wd;

   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_empty = (r_wr == r_rd);
   assign w_head  = r_mem[r_rd[AW-1:0]];

   // abort forces ready low so a same-cycle push cannot survive the flush
   assign desc_ready = ~reset & ~w_full & ~abort;
   assign w_push     = desc_valid & desc_ready;
   assign w_pop      = (r_state == IDLE) & ~w_empty & ~abort;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr[AW-1:0]] <= desc_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push)
            r_wr <= r_wr + 1'b1;
         if (abort)
            r_rd <= r_wr;
         else if (w_pop)
            r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cfg        <= '0;
         r_tag        <= '0;
         r_status     <= '0;
         r_start      <= 1'b0;
         r_soft_reset <= 1'b0;
         r_cmp_valid  <= 1'b0;
         r_wd         <= '0;
      end else begin
         r_start      <= 1'b0;
         r_soft_reset <= 1'b0;
         // Pulse outputs are set on entry to their state so they are high exactly there
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_cfg   <= w_head[CFG_W-1:0];
                  r_tag   <= w_head[DESC_W-1:CFG_W];
                  r_state <= LOAD;
               end
            end
            LOAD, START, ARM: begin
               if (r_state == START)
                  r_wd <= '0;
               if (abort) begin
                  r_status     <= 2'b11;
                  r_soft_reset <= 1'b1;
                  r_state      <= KILL;
               end else if (r_state == LOAD) begin
                  r_start <= 1'b1;
                  r_state <= START;
               end else if (r_state == START) begin
                  r_state <= ARM;
               end else begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_wd <= r_wd + 1'b1;
               if (abort) begin
                  r_status     <= 2'b11;
                  r_soft_reset <= 1'b1;
                  r_state      <= KILL;
               end else if (conv_done) begin
                  r_status    <= conv_ovf ? 2'b01 : 2'b00;
                  r_cmp_valid <= 1'b1;
                  r_state     <= CMP;
               end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                  r_status     <= 2'b10;
                  r_soft_reset <= 1'b1;
                  r_state      <= KILL;
               end
            end
            KILL: begin
               r_cmp_valid <= 1'b1;
               r_state     <= CMP;
            end
            CMP: begin
               if (cmp_ready) begin
                  r_cmp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cfg             = r_cfg;
   assign conv_start      = r_start;
   assign conv_soft_reset = r_soft_reset;
   assign cmp_valid       = r_cmp_valid;
   assign cmp_tag         = r_tag;
   assign cmp_status      = r_status;
   assign q_count         = r_wr - r_rd;
   assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_conv_job_sched.sv
// Directed bench for conv_job_sched: queueing, sequencing, watchdog, abort and
// completion back-pressure, with hand-derived expected values.
module tb_conv_job_sched;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 24;
   localparam int CFG_W   = 35;
   localparam int DESC_W  = CFG_W + TAG_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              desc_valid = 1'b0;
   logic              desc_ready;
   logic [DESC_W-1:0] desc_data = '0;
   logic              abort = 1'b0;
   logic [CFG_W-1:0]  cfg;
   logic              conv_start;
   logic              conv_soft_reset;
   logic              conv_done = 1'b0;
   logic              conv_ovf = 1'b0;
   logic              cmp_valid;
   logic              cmp_ready = 1'b0;
   logic [TAG_W-1:0]  cmp_tag;
   logic [1:0]        cmp_status;
   logic [CNT_W-1:0]  q_count;
   logic              busy;

   conv_job_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_data(desc_data), .abort(abort), .cfg(cfg), .conv_start(conv_start),
      .conv_soft_reset(conv_soft_reset), .conv_done(conv_done), .conv_ovf(conv_ovf),
      .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
      .cmp_status(cmp_status), .q_count(q_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int n_start = 0;
   int n_srst = 0;
   int qmax = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && conv_start) n_start <= n_start + 1;
      if (!reset && conv_soft_reset) n_srst <= n_srst + 1;
      if (int'(q_count) > qmax) qmax <= int'(q_count);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CFG_W-1:0] cfgv(input int i);
      return CFG_W'(64'h1_2345_6789 + 64'(i) * 64'h0_0F0F_1111);
   endfunction

   task automatic push(input logic [TAG_W-1:0] t, input logic [CFG_W-1:0] c);
      int n = 0;
      desc_valid = 1'b1;
      desc_data  = {t, c};
      while (!desc_ready && n < 100) begin tick(); n++; end
      if (n == 100) chk("push_timeout", desc_ready, 1);
      tick();
      desc_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!conv_start && n < 200) begin tick(); n++; end
      chk(tag, conv_start, 1);
   endtask

   task automatic wait_cmp(input string tag);
      int n = 0;
      while (!cmp_valid && n < 200) begin tick(); n++; end
      chk(tag, cmp_valid, 1);
   endtask

   task automatic ack();
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int s0, r0, last, stable, n;

      // reset state
      repeat (3) tick();
      chk("rst_ready_in_reset", desc_ready, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      tick();
      chk("rst_ready", desc_ready, 1);
      chk("rst_qcount", q_count, 0);
      chk("rst_cfg", cfg, 0);
      chk("rst_cmp_valid", cmp_valid, 0);
      chk("rst_start", conv_start, 0);

      // 1) single job, done 20 cycles after start
      s0 = n_start;
      push(4'd3, cfgv(0));
      wait_start("t1_start");
      chk("t1_cfg", cfg, cfgv(0));
      repeat (20) tick();
      chk("t1_no_cmp_yet", cmp_valid, 0);
      conv_done = 1'b1;
      wait_cmp("t1_cmp");
      conv_done = 1'b0;
      chk("t1_tag", cmp_tag, 3);
      chk("t1_status", cmp_status, 0);
      ack();
      chk("t1_busy", busy, 0);
      chk("t1_cmp_cleared", cmp_valid, 0);
      chk("t1_nstart", n_start - s0, 1);

      // 2) DEPTH+1 back-to-back pushes, then full-with-pop corner
      qmax = 0;
      r0 = n_srst;
      for (int i = 0; i < DEPTH + 1; i++) push(TAG_W'(i), cfgv(i + 1));
      chk("t2_q_full", q_count, DEPTH);
      chk("t2_ready_low", desc_ready, 0);
      desc_valid = 1'b1;
      desc_data  = {4'd9, cfgv(9)};
      repeat (3) tick();
      chk("t2_no_push_full", q_count, DEPTH);
      conv_done = 1'b1;
      wait_cmp("t2_cmp");
      conv_done = 1'b0;
      ack();
      tick();
      chk("t2_pop_no_push", q_count, DEPTH - 1);
      tick();
      chk("t2_push_after", q_count, DEPTH);
      desc_valid = 1'b0;
      chk("t2_qmax", qmax, DEPTH);
      reset = 1'b1;
      tick();
      chk("t2_rst_busy", busy, 0);
      chk("t2_rst_q", q_count, 0);
      chk("t2_rst_cfg", cfg, 0);
      chk("t2_rst_nosrst", n_srst - r0, 0);
      reset = 1'b0;
      tick();

      // 3) three jobs, done 5 cycles after each start, cmp_ready tied high
      cmp_ready = 1'b1;
      last = -100;
      for (int i = 0; i < 3; i++) push(TAG_W'(5 + i), cfgv(10 + i));
      for (int j = 0; j < 3; j++) begin
         wait_start($sformatf("t3_start%0d", j));
         chk($sformatf("t3_cfg%0d", j), cfg, cfgv(10 + j));
         chk($sformatf("t3_gap%0d", j), (cyc - last) >= 5, 1);
         last = cyc;
         repeat (5) tick();
         conv_done = 1'b1;
         wait_cmp($sformatf("t3_cmp%0d", j));
         conv_done = 1'b0;
         chk($sformatf("t3_tag%0d", j), cmp_tag, 5 + j);
         chk($sformatf("t3_status%0d", j), cmp_status, 0);
         tick();
      end
      cmp_ready = 1'b0;
      chk("t3_busy", busy, 0);

      // 4) watchdog expiry, then done on the expiry cycle
      r0 = n_srst;
      push(4'hA, cfgv(20));
      wait_start("t4_start");
      n = 0;
      while (!conv_soft_reset && n < 100) begin tick(); n++; end
      chk("t4_srst_delay", n, TIMEOUT + 2);
      tick();
      chk("t4_srst_width", conv_soft_reset, 0);
      wait_cmp("t4_cmp");
      chk("t4_tag", cmp_tag, 4'hA);
      chk("t4_status", cmp_status, 2);
      ack();
      push(4'hB, cfgv(21));
      wait_start("t4b_start");
      repeat (TIMEOUT + 1) tick();
      chk("t4b_no_srst_yet", conv_soft_reset, 0);
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      chk("t4b_cmp", cmp_valid, 1);
      chk("t4b_status", cmp_status, 0);
      chk("t4b_nsrst", n_srst - r0, 1);
      ack();

      // 5) abort in RUN with two queued
      push(4'h1, cfgv(30));
      push(4'h2, cfgv(31));
      push(4'h3, cfgv(32));
      wait_start("t5_start");
      repeat (3) tick();
      chk("t5_q2", q_count, 2);
      s0 = n_start;
      r0 = n_srst;
      abort = 1'b1;
      desc_valid = 1'b1;
      desc_data = {4'h7, cfgv(33)};
      #1;
      chk("t5_ready_abort", desc_ready, 0);
      tick();
      abort = 1'b0;
      desc_valid = 1'b0;
      chk("t5_q0", q_count, 0);
      chk("t5_srst", conv_soft_reset, 1);
      wait_cmp("t5_cmp");
      chk("t5_tag", cmp_tag, 1);
      chk("t5_status", cmp_status, 3);
      ack();
      repeat (20) tick();
      chk("t5_nstart", n_start - s0, 0);
      chk("t5_nsrst", n_srst - r0, 1);
      chk("t5_busy", busy, 0);

      // 6) completion back-pressure with overflow status
      push(4'hC, cfgv(40));
      push(4'hD, cfgv(41));
      wait_start("t6_start");
      repeat (3) tick();
      conv_done = 1'b1;
      conv_ovf = 1'b1;
      wait_cmp("t6_cmp");
      conv_done = 1'b0;
      conv_ovf = 1'b0;
      s0 = n_start;
      stable = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!(cmp_valid === 1'b1 && cmp_tag === 4'hC && cmp_status === 2'b01)) stable = 0;
      end
      chk("t6_stable", stable, 1);
      chk("t6_status", cmp_status, 1);
      chk("t6_held_nstart", n_start - s0, 0);
      chk("t6_q1", q_count, 1);
      ack();
      wait_start("t6_next_start");
      chk("t6_next_cfg", cfg, cfgv(41));
      repeat (3) tick();
      conv_done = 1'b1;
      wait_cmp("t6_next_cmp");
      conv_done = 1'b0;
      chk("t6_next_tag", cmp_tag, 4'hD);
      ack();
      chk("t6_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
